// File: rtl/mem_access_ctrl_if.sv
// Bundle between the MEM pipeline stage, the access controller and the data memory.
// Field names keep the i_/o_ direction of the controller, which is the slave side.
interface mem_access_ctrl_if #(
    parameter int ADDR_SIZE = 5,
    parameter int DATA_SIZE = 32
);
    // Handshake: a request (i_mem_read/i_mem_write) is taken in an idle cycle with
    // i_enable high. While o_stall is high the requester keeps every request field
    // stable. The cycle after o_stall falls still presents the finished request and
    // is ignored. o_load_valid and o_misaligned are one-cycle completion strobes.
    logic                 i_enable;
    logic                 i_mem_read;
    logic                 i_mem_write;
    logic [1:0]           i_size;
    logic                 i_unsigned;
    logic [31:0]          i_addr;
    logic [DATA_SIZE-1:0] i_write_data;
    logic [DATA_SIZE-1:0] i_mem_read_data;

    logic                 o_stall;
    logic [DATA_SIZE-1:0] o_load_data;
    logic                 o_load_valid;
    logic                 o_misaligned;
    logic                 o_mem_enable;
    logic                 o_mem_write;
    logic                 o_mem_read;
    logic [ADDR_SIZE-1:0] o_mem_addr;
    logic [DATA_SIZE-1:0] o_mem_write_data;

    modport slave (
        input  i_enable, i_mem_read, i_mem_write, i_size, i_unsigned, i_addr,
               i_write_data, i_mem_read_data,
        output o_stall, o_load_data, o_load_valid, o_misaligned, o_mem_enable,
               o_mem_write, o_mem_read, o_mem_addr, o_mem_write_data
    );

    modport master (
        output i_enable, i_mem_read, i_mem_write, i_size, i_unsigned, i_addr,
               i_write_data, i_mem_read_data,
        input  o_stall, o_load_data, o_load_valid, o_misaligned, o_mem_enable,
               o_mem_write, o_mem_read, o_mem_addr, o_mem_write_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: byte/halfword/word loads with extension, word stores
// in one cycle, sub-word stores via read-modify-write, misalignment rejection.
module mem_access_ctrl #(
    parameter int ADDR_SIZE = 5,
    parameter int DATA_SIZE = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    mem_access_ctrl_if.slave bus,
    output logic [1:0]       o_state
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WAIT  = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]           lat_size;
    logic [1:0]           lat_off;
    logic                 lat_unsigned;
    logic                 lat_load;
    logic [ADDR_SIZE-1:0] lat_addr;
    logic [DATA_SIZE-1:0] lat_data;

    logic                 rd_fresh;
    logic [DATA_SIZE-1:0] rd_buf;
    logic [DATA_SIZE-1:0] rd_word;

    logic                 misaligned_q;
    logic [DATA_SIZE-1:0] load_data_q;

    logic                 active;
    logic                 req;
    logic                 sub_word;
    logic                 misaligned;
    logic                 accept;
    logic                 start_wait;
    logic [4:0]           lane_shift;
    logic [DATA_SIZE-1:0] lane_mask;
    logic [DATA_SIZE-1:0] merged;
    logic [DATA_SIZE-1:0] shifted;
    logic [DATA_SIZE-1:0] load_fmt;

    logic                 stall;
    logic                 mem_read;
    logic                 mem_write;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic                 unused_bits;

    // Holding reset keeps the combinational memory controls quiet as well.
    assign active     = bus.i_enable && i_reset;
    assign req        = bus.i_mem_read || bus.i_mem_write;
    assign sub_word   = !bus.i_size[1];
    assign misaligned = (bus.i_size == 2'b01 && bus.i_addr[0]) ||
                        (bus.i_size[1] && bus.i_addr[1:0] != 2'b00);
    assign accept     = (state == IDLE) && active && req;
    assign start_wait = accept && !misaligned && (bus.i_mem_read || sub_word);

    // Memory data is only present the cycle after the read; later cycles (after an
    // enable freeze) use the captured copy.
    assign rd_word    = rd_fresh ? bus.i_mem_read_data : rd_buf;

    assign lane_shift = {lat_off, 3'b000};
    assign lane_mask  = ((lat_size == 2'b00) ? DATA_SIZE'(8'hFF) : DATA_SIZE'(16'hFFFF))
                        << lane_shift;
    assign merged     = (rd_word & ~lane_mask) | ((lat_data << lane_shift) & lane_mask);
    assign shifted    = rd_word >> lane_shift;

    always_comb begin
        load_fmt = rd_word;
        case (lat_size)
            2'b00:   load_fmt = {{(DATA_SIZE-8){!lat_unsigned && shifted[7]}}, shifted[7:0]};
            2'b01:   load_fmt = {{(DATA_SIZE-16){!lat_unsigned && shifted[15]}}, shifted[15:0]};
            default: load_fmt = rd_word;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else if (bus.i_enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (accept && !misaligned) begin
                    mem_addr = bus.i_addr[ADDR_SIZE+1:2];
                    if (bus.i_mem_read) begin
                        mem_read  = 1'b1;
                        stall     = 1'b1;
                        state_nxt = LOAD_WAIT;
                    end else if (sub_word) begin
                        mem_read  = 1'b1;
                        stall     = 1'b1;
                        state_nxt = RMW_WAIT;
                    end else begin
                        mem_write = 1'b1;
                        mem_wdata = bus.i_write_data;
                    end
                end
            end
            LOAD_WAIT: begin
                stall = 1'b1;
                if (active) state_nxt = DONE;
            end
            RMW_WAIT: begin
                stall = 1'b1;
                if (active) begin
                    mem_write = 1'b1;
                    mem_addr  = lat_addr;
                    mem_wdata = merged;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (active) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            lat_size     <= 2'b00;
            lat_off      <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_load     <= 1'b0;
            lat_addr     <= '0;
            lat_data     <= '0;
            rd_fresh     <= 1'b0;
            rd_buf       <= '0;
            misaligned_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            rd_fresh <= mem_read;
            if (rd_fresh) rd_buf <= bus.i_mem_read_data;
            if (bus.i_enable) begin
                misaligned_q <= accept && misaligned;
                if (accept && misaligned) begin
                    load_data_q <= '0;
                end else if (state == LOAD_WAIT) begin
                    load_data_q <= load_fmt;
                end
                if (start_wait) begin
                    lat_size     <= bus.i_size;
                    lat_off      <= bus.i_addr[1:0];
                    lat_unsigned <= bus.i_unsigned;
                    lat_load     <= bus.i_mem_read;
                    lat_addr     <= bus.i_addr[ADDR_SIZE+1:2];
                    lat_data     <= bus.i_write_data;
                end
            end
        end
    end

    assign bus.o_stall          = stall;
    assign bus.o_mem_read       = mem_read;
    assign bus.o_mem_write      = mem_write;
    assign bus.o_mem_enable     = mem_read || mem_write;
    assign bus.o_mem_addr       = mem_addr;
    assign bus.o_mem_write_data = mem_wdata;
    assign bus.o_load_data      = load_data_q;
    assign bus.o_load_valid     = (state == DONE) && lat_load;
    assign bus.o_misaligned     = misaligned_q;
    assign o_state              = state;

    assign unused_bits = ^{bus.i_addr[31:ADDR_SIZE+2], shifted[DATA_SIZE-1:16]};
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 5: word-address width toward data memory.
REQ-002 Parameter DATA_SIZE, default 32: data word width.
REQ-003 i_clock  in  1  single clock; all state changes on rising edge.
REQ-004 i_reset  in  1  reset is asynchronous and active-low.
REQ-005 i_enable  in  1  stage enable; low freezes all state and outputs.
REQ-006 i_mem_read  in  1  load request from the MEM stage.
REQ-007 i_mem_write  in  1  store request from the MEM stage.
REQ-008 i_size  in  2  access size: 00 byte, 01 halfword, 10/11 word.
REQ-009 i_unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-010 i_addr  in  32  byte address from the ALU.
REQ-011 i_write_data  in  DATA_SIZE  store data, right-aligned.
REQ-012 o_stall  out  1  hold the upstream pipeline; the request stays stable while high.
REQ-013 o_load_data  out  DATA_SIZE  formatted load result.
REQ-014 o_load_valid  out  1  single-cycle pulse; o_load_data is valid.
REQ-015 o_misaligned  out  1  single-cycle pulse; the access was rejected.
REQ-016 o_mem_enable, o_mem_write, o_mem_read  out  1 each  data-memory controls.
REQ-017 o_mem_addr  out  ADDR_SIZE  word address, equal to i_addr[ADDR_SIZE+1:2].
REQ-018 o_mem_write_data  out  DATA_SIZE  word written to memory.
REQ-019 i_mem_read_data  in  DATA_SIZE  memory read data.

Function
REQ-020 Memory model: reads are registered; data appears in the cycle after o_mem_read is sampled high and is 0 otherwise; a simultaneous write does not affect the data read in that cycle.
REQ-021 Byte lanes are little-endian: offset k maps to bits [8k+7:8k]; a halfword at offset 2 maps to [31:16].
REQ-022 States: IDLE, LOAD_WAIT, RMW_WAIT, DONE.
REQ-023 Request acceptance is evaluated only in IDLE with i_enable=1.
REQ-024 If i_mem_read and i_mem_write are both high, the block ignores the write and performs the load.
REQ-025 Misalignment is a halfword with i_addr[0]=1 or a word with i_addr[1:0]!=0; when detected:
  - no memory access;
  - o_misaligned pulses the next cycle;
  - o_load_data is 0 and o_load_valid is 0;
  - state stays IDLE; o_stall is 0.
REQ-026 Word store: in IDLE, o_mem_enable=o_mem_write=1 and o_mem_write_data=i_write_data in the same cycle; o_stall=0; state stays IDLE; 0 stall cycles.
REQ-027 Load, IDLE cycle: o_mem_read=1; o_stall=1 combinationally; size, offset and i_unsigned are latched; next state LOAD_WAIT.
REQ-028 Load, LOAD_WAIT: o_stall=1; the selected lane is extracted and sign- or zero-extended into the o_load_data register; next state DONE.
REQ-029 Sub-word store, IDLE cycle: o_mem_read=1; o_stall=1; offset, size and data are latched; next state RMW_WAIT.
REQ-030 Sub-word store, RMW_WAIT: o_mem_write=1 with the read word and the target lane replaced; o_stall=1; next state DONE.
REQ-031 DONE state:
  - o_stall=0;
  - o_load_valid=1 for loads only;
  - inputs are ignored, because the completed request is still presented;
  - next state IDLE.
REQ-032 Loads and sub-word stores therefore cost exactly 2 stall cycles; o_load_data holds its value until the next load completes.
REQ-033 o_mem_enable is high in every cycle where o_mem_read or o_mem_write is high, and low otherwise.
REQ-034 With i_enable=0 in any state, the state, latches and outputs hold, and all memory controls are low.

Reset
REQ-035 While i_reset=0:
  - state is IDLE;
  - all outputs are 0, including o_stall, o_load_data and the flags;
  - latched request fields are cleared.
REQ-036 Reset asserted mid-operation abandons any pending read-modify-write write; the memory is not written.
REQ-037 After reset is released, the first accepted request is evaluated at the next rising edge.

Verification
REQ-038 Word store 0xDEADBEEF to byte address 0x08 -> memory word 2 = 0xDEADBEEF, no stall cycle.
REQ-039 Signed byte load at 0x0B with word 2 = 0x80FF7F01 -> o_load_data 0xFFFFFF80 with o_load_valid in the 3rd cycle; o_stall high for exactly 2 cycles.
REQ-040 Halfword store 0x1234 to 0x0A with word 2 = 0xAABBCCDD -> word 2 = 0x1234CCDD after RMW_WAIT; an unsigned halfword load at 0x0A returns 0x00001234.
REQ-041 Word load at 0x06 -> o_misaligned pulse; no o_mem_read; o_stall stays 0.
REQ-042 Reset pulled low during RMW_WAIT of a byte store -> memory unchanged; outputs 0; state IDLE.
REQ-043 i_enable low for 3 cycles during LOAD_WAIT -> o_stall held at 1, no memory controls asserted; the load result is still correct after i_enable returns high.
